mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised successor MEM-stage load/store unit for the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. It steers byte and halfword lanes by address, supports signed and unsigned loads, and flags misaligned accesses. It runs a request/acknowledge handshake with variable-latency data memory and stalls the upstream pipeline while waiting. A bus-error timeout bounds the wait, and results go out through a registered MEM/WB output.

## Interface
Parameters:
- ADDR_W, 32, address width (pc and data address)
- REG_W, 5, destination register index width
- CTRL_W, 3, WB-stage control bits passed through
- TIMEOUT, 16, maximum WAIT cycles before bus error; 0 disables the timeout

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- valid_in  in  1  EX/MEM holds a valid instruction
- pc_in  in  ADDR_W  instruction pc
- addr_in  in  ADDR_W  ALU result or effective address
- wdata_in  in  32  store data from EX/MEM
- wb_data  in  32  WB-stage result, used for store forwarding
- forward_e  in  1  1 selects wb_data as store data
- mem_read, mem_write  in  1 each  access type; mem_write wins if both are set
- size  in  2  00 word, 01 half, 10 byte, 11 treated as word
- sign_ext  in  1  1 sign-extends loads, 0 zero-extends
- ctrl_in  in  CTRL_W  WB control
- regdst_in  in  REG_W  destination register
- stall_out  out  1  holds upstream stages
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  one-cycle completion; rdata valid in the same cycle
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse per completed instruction
- pc_out, addr_out  out  ADDR_W  registered copies
- data_out  out  32  extended load data, or the ALU result for non-loads
- regdst_out  out  REG_W
- ctrl_out  out  CTRL_W
- exc_misalign, exc_bus  out  1 each  exception flags, qualified by wb_valid

## Operation
- FSM states: IDLE and WAIT.
- In IDLE, an instruction is accepted when valid_in=1.
  - Accept captures pc, addr, size, sign_ext, ctrl, regdst and the store data (the forward_e mux is evaluated at accept).
- Non-memory instruction: completes next edge. wb_valid=1, data_out=addr_in, no mem_req.
- Misalignment:
  - Half is misaligned when addr[0]=1; word when addr[1:0]!=0; byte never.
  - Misaligned access completes next edge with exc_misalign=1, data_out=0, ctrl_out=0 (writeback suppressed), no mem_req.
- Aligned memory access: go to WAIT; mem_req=1 for as long as state is WAIT.
- Byte enables: byte is 4'b0001<<addr[1:0]; half is 4'b0011<<addr[1:0]; word is 4'b1111.
- mem_wdata: byte is {4{d[7:0]}}, half is {2{d[15:0]}}, word is d.
- Load data: select the lane by addr[1:0], then sign- or zero-extend it to 32 bits per sign_ext.
- Completion on mem_ack in WAIT:
  - Register the result; wb_valid=1; store completions give data_out=addr.
  - Return to IDLE.
- Timeout: a counter increments every WAIT cycle without ack.
  - When the count reaches TIMEOUT (TIMEOUT>0): drop mem_req, complete with exc_bus=1, data_out=0, ctrl_out=0.
  - mem_ack and the timeout in the same cycle: ack wins, no exception.
- stall_out = (state==WAIT) && !mem_ack && !timeout_hit.
  - While stalled, valid_in is ignored and upstream must hold its register.
- Reset: state IDLE, counter 0, every output 0 (mem_req, wb_valid, exc flags, data/pc/addr/regdst/ctrl outputs).
  - Reset asserted during WAIT drops mem_req at that edge. A late mem_ack after reset is ignored.

## Timing
- Non-memory or misaligned instruction: accepted at edge T0, outputs valid after T0; 0 stall cycles; back-to-back throughput of one per cycle.
- Memory access: accepted at T0; mem_req high from T0 through the ack cycle.
- Ack in the first WAIT cycle gives outputs after T1: one-cycle latency, zero stall cycles.
- Ack after k WAIT cycles gives k-1 stall cycles; the next instruction is accepted at the edge after the ack cycle.
- mem_addr, mem_be, mem_we and mem_wdata are stable for the whole request.
- wb_valid is low in every cycle without a completion; the other outputs hold their last values.

## Test plan
- lb, sign_ext=1, addr=0x1003, ack next cycle, mem_rdata=0x80FF_1234 -> mem_be=1000, data_out=0xFFFF_FF80, wb_valid one pulse, no stall.
- lhu, sign_ext=0, addr=0x2002, rdata=0xBEEF_0000, ack after 3 WAIT cycles -> stall_out high for 2 cycles, data_out=0x0000_BEEF.
- sb with forward_e=1, wb_data=0x0000_00A5, addr=0x11 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, mem_addr=0x10.
- lw at addr=0x6 -> no mem_req, exc_misalign=1, ctrl_out=0, wb_valid next cycle. sh at 0x5 -> same result.
- TIMEOUT=4, no ack -> mem_req drops after 4 WAIT cycles, exc_bus=1, stall releases; ack coinciding with cycle 4 -> normal completion.
- rst_n low during WAIT -> mem_req=0 and all outputs 0 at that edge; a later mem_ack produces no wb_valid.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: lane steering, sign/zero extension, misalignment detection,
// req/ack handshake with bus-error timeout, and a registered MEM/WB output.
module mem_stage_lsu #(
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int CTRL_W  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    input  logic [31:0]       wb_data,
    input  logic              forward_e,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [REG_W-1:0]  regdst_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [31:0]       data_out,
    output logic [REG_W-1:0]  regdst_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              exc_misalign,
    output logic              exc_bus
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic        TO_EN   = (TIMEOUT > 0);
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b01:   return off[0];
            2'b10:   return 1'b0;
            default: return (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b01:   return 4'b0011 << off;
            2'b10:   return 4'b0001 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b01:   return {2{d[15:0]}};
            2'b10:   return {4{d[7:0]}};
            default: return d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend it.
    function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic sx,
                                             input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (sz)
            2'b01:   return sx ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
            2'b10:   return sx ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            default: return rd;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d, we_q, we_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [REG_W-1:0]    regdst_q, regdst_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d, addr_out_q, addr_out_d;
    logic [31:0]         data_out_q, data_out_d;
    logic [REG_W-1:0]    regdst_out_q, regdst_out_d;
    logic [CTRL_W-1:0]   ctrl_out_q, ctrl_out_d;
    logic                misalign_q, misalign_d, bus_q, bus_d;

    logic                timeout_hit_s;
    logic [31:0]         store_data_s;

    assign store_data_s  = forward_e ? wb_data : wdata_in;
    assign timeout_hit_s = TO_EN && (state_q == S_WAIT) && !mem_ack && (cnt_q == TO_LAST);

    assign mem_req      = (state_q == S_WAIT);
    assign mem_we       = mem_req & we_q;
    assign mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;
    assign stall_out    = mem_req & ~mem_ack & ~timeout_hit_s;
    assign wb_valid     = wb_valid_q;
    assign pc_out       = pc_out_q;
    assign addr_out     = addr_out_q;
    assign data_out     = data_out_q;
    assign regdst_out   = regdst_out_q;
    assign ctrl_out     = ctrl_out_q;
    assign exc_misalign = misalign_q;
    assign exc_bus      = bus_q;

    // Next-state, request capture and MEM/WB result selection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sign_d       = sign_q;
        we_d         = we_q;
        ctrl_d       = ctrl_q;
        regdst_d     = regdst_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        wb_valid_d   = 1'b0;
        pc_out_d     = pc_out_q;
        addr_out_d   = addr_out_q;
        data_out_d   = data_out_q;
        regdst_out_d = regdst_out_q;
        ctrl_out_d   = ctrl_out_q;
        misalign_d   = misalign_q;
        bus_d        = bus_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    pc_d     = pc_in;
                    addr_d   = addr_in;
                    size_d   = size;
                    sign_d   = sign_ext;
                    we_d     = mem_write;
                    ctrl_d   = ctrl_in;
                    regdst_d = regdst_in;
                    be_d     = lane_be(size, addr_in[1:0]);
                    wdata_d  = lane_wdata(size, store_data_s);
                    if (!(mem_read || mem_write)) begin
                        wb_valid_d   = 1'b1;
                        pc_out_d     = pc_in;
                        addr_out_d   = addr_in;
                        regdst_out_d = regdst_in;
                        ctrl_out_d   = ctrl_in;
                        data_out_d   = 32'(addr_in);
                        misalign_d   = 1'b0;
                        bus_d        = 1'b0;
                    end else if (is_misaligned(size, addr_in[1:0])) begin
                        wb_valid_d   = 1'b1;
                        pc_out_d     = pc_in;
                        addr_out_d   = addr_in;
                        regdst_out_d = regdst_in;
                        ctrl_out_d   = '0;
                        data_out_d   = 32'd0;
                        misalign_d   = 1'b1;
                        bus_d        = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 32'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_ack || timeout_hit_s) begin
                    state_d      = S_IDLE;
                    cnt_d        = 32'd0;
                    wb_valid_d   = 1'b1;
                    pc_out_d     = pc_q;
                    addr_out_d   = addr_q;
                    regdst_out_d = regdst_q;
                    misalign_d   = 1'b0;
                    if (mem_ack) begin
                        ctrl_out_d = ctrl_q;
                        data_out_d = we_q ? 32'(addr_q)
                                          : load_ext(size_q, sign_q, addr_q[1:0], mem_rdata);
                        bus_d      = 1'b0;
                    end else begin
                        ctrl_out_d = '0;
                        data_out_d = 32'd0;
                        bus_d      = 1'b1;
                    end
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            pc_q         <= '0;
            addr_q       <= '0;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            we_q         <= 1'b0;
            ctrl_q       <= '0;
            regdst_q     <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'd0;
            wb_valid_q   <= 1'b0;
            pc_out_q     <= '0;
            addr_out_q   <= '0;
            data_out_q   <= 32'd0;
            regdst_out_q <= '0;
            ctrl_out_q   <= '0;
            misalign_q   <= 1'b0;
            bus_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            we_q         <= we_d;
            ctrl_q       <= ctrl_d;
            regdst_q     <= regdst_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            wb_valid_q   <= wb_valid_d;
            pc_out_q     <= pc_out_d;
            addr_out_q   <= addr_out_d;
            data_out_q   <= data_out_d;
            regdst_out_q <= regdst_out_d;
            ctrl_out_q   <= ctrl_out_d;
            misalign_q   <= misalign_d;
            bus_q        <= bus_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed plus randomized bench for mem_stage_lsu against an arithmetic reference model.
module tb_mem_stage_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, forward_e, mem_read, mem_write, sign_ext, mem_ack;
    logic [31:0] pc_in, addr_in, wdata_in, wb_data, mem_rdata;
    logic [1:0]  size;
    logic [2:0]  ctrl_in;
    logic [4:0]  regdst_in;
    logic        stall_out, mem_req, mem_we, wb_valid, exc_misalign, exc_bus;
    logic [31:0] mem_addr, mem_wdata, pc_out, addr_out, data_out;
    logic [3:0]  mem_be;
    logic [4:0]  regdst_out;
    logic [2:0]  ctrl_out;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_lsu #(.ADDR_W(32), .REG_W(5), .CTRL_W(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in), .addr_in(addr_in),
        .wdata_in(wdata_in), .wb_data(wb_data), .forward_e(forward_e), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .ctrl_in(ctrl_in),
        .regdst_in(regdst_in), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .pc_out(pc_out), .addr_out(addr_out),
        .data_out(data_out), .regdst_out(regdst_out), .ctrl_out(ctrl_out),
        .exc_misalign(exc_misalign), .exc_bus(exc_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
    endfunction

    // op: 0 non-memory, 1 load, 2 store. k: WAIT cycle carrying the ack (0 = never).
    task automatic run_txn(input int op, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input logic fw,
                           input logic [31:0] wbd, input logic [31:0] rd, input int k);
        int          nb, off, bits;
        logic        is_mem, mis, bus, done, ack;
        logic [31:0] e_be, e_wd, e_data, sd, mask, v, p;
        logic [2:0]  c;
        logic [4:0]  r;
        nb     = nbytes(sz);
        off    = int'(a % 4);
        bits   = 8 * nb;
        is_mem = (op != 0);
        mis    = is_mem && ((a % nb) != 0);
        bus    = is_mem && !mis && (k < 1 || k > TO);
        e_be   = ((32'd1 << nb) - 32'd1) << off;
        sd     = fw ? wbd : wd;
        e_wd   = (nb == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                 (nb == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        v      = rd >> (8 * off);
        if (nb < 4) begin
            mask = (32'd1 << bits) - 32'd1;
            v    = v & mask;
            if (sx && v[bits-1]) v = v | ~mask;
        end
        p = $urandom; c = 3'($urandom_range(1, 7)); r = 5'($urandom);
        if (!is_mem || op == 2) e_data = a;
        else e_data = v;
        if (mis || bus) e_data = 32'd0;

        valid_in = 1'b1; pc_in = p; addr_in = a; size = sz; sign_ext = sx;
        wdata_in = wd; forward_e = fw; wb_data = wbd; ctrl_in = c; regdst_in = r;
        mem_read = (op == 1) || (op == 2 && $urandom_range(0, 1) == 1);
        mem_write = (op == 2);
        @(posedge clk); #1;
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        pc_in = $urandom; addr_in = $urandom; wdata_in = $urandom; wb_data = $urandom;

        if (is_mem && !mis) begin
            chk("req_at_accept", mem_req, 1'b1);
            chk("mem_we", mem_we, (op == 2));
            chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("mem_be", mem_be, e_be);
            if (op == 2) chk("mem_wdata", mem_wdata, e_wd);
            done = 1'b0;
            for (int i = 1; i <= TO + 2 && !done; i++) begin
                ack = (i == k);
                mem_ack = ack;
                mem_rdata = ack ? rd : $urandom;
                valid_in = 1'b1;
                #1;
                chk("stall", stall_out, !ack && (i != TO));
                chk("req_held", mem_req, 1'b1);
                chk("addr_held", mem_addr, a & 32'hFFFF_FFFC);
                chk("be_held", mem_be, e_be);
                @(posedge clk); #1;
                mem_ack = 1'b0; valid_in = 1'b0;
                if (ack || i == TO) done = 1'b1;
            end
            if (!done) chk("wait_bound", 32'd0, 32'd1);
        end else begin
            chk("no_req", mem_req, 1'b0);
        end
        chk("wb_valid", wb_valid, 1'b1);
        chk("data_out", data_out, e_data);
        chk("ctrl_out", ctrl_out, (mis || bus) ? 3'd0 : c);
        chk("exc_misalign", exc_misalign, mis);
        chk("exc_bus", exc_bus, bus);
        chk("regdst_out", regdst_out, r);
        chk("pc_out", pc_out, p);
        chk("addr_out", addr_out, a);
        chk("req_dropped", mem_req, 1'b0);
        @(posedge clk); #1;
        chk("wb_pulse", wb_valid, 1'b0);
        chk("data_hold", data_out, e_data);
    endtask

    initial begin
        logic [1:0]  rsz;
        logic [31:0] ra;
        int          rop, rk;
        rst_n = 1'b0; valid_in = 1'b0; forward_e = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        sign_ext = 1'b0; mem_ack = 1'b0; pc_in = 32'd0; addr_in = 32'd0; wdata_in = 32'd0;
        wb_data = 32'd0; mem_rdata = 32'd0; size = 2'b00; ctrl_in = 3'd0; regdst_in = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_stall", stall_out, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 2'b10, 1'b1, 32'h0000_1003, 32'd0, 1'b0, 32'd0, 32'h80FF_1234, 1);
        run_txn(1, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 1'b0, 32'd0, 32'hBEEF_0000, 3);
        run_txn(2, 2'b10, 1'b0, 32'h0000_0011, 32'h1234_5678, 1'b1, 32'h0000_00A5, 32'd0, 1);
        run_txn(1, 2'b00, 1'b0, 32'h0000_0006, 32'd0, 1'b0, 32'd0, 32'd0, 1);
        run_txn(2, 2'b01, 1'b0, 32'h0000_0005, 32'hCAFE_BABE, 1'b0, 32'd0, 32'd0, 1);
        run_txn(0, 2'b00, 1'b0, 32'h0000_0123, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        run_txn(1, 2'b00, 1'b0, 32'h0000_0040, 32'd0, 1'b0, 32'd0, 32'h1111_2222, 0);
        run_txn(2, 2'b11, 1'b0, 32'h0000_0044, 32'h7777_8888, 1'b0, 32'd0, 32'd0, TO);
        run_txn(1, 2'b01, 1'b1, 32'h0000_0102, 32'd0, 1'b0, 32'd0, 32'h8001_7FFF, TO);

        // Reset while waiting: everything clears and a late ack is ignored.
        valid_in = 1'b1; mem_read = 1'b1; size = 2'b00; addr_in = 32'h0000_0200;
        pc_in = 32'h0000_0ABC; ctrl_in = 3'd5; regdst_in = 5'd7;
        @(posedge clk); #1;
        valid_in = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        chk("wait_req", mem_req, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstw_mem_req", mem_req, 1'b0);
        chk("rstw_stall", stall_out, 1'b0);
        chk("rstw_wb_valid", wb_valid, 1'b0);
        chk("rstw_data_out", data_out, 32'd0);
        chk("rstw_pc_out", pc_out, 32'd0);
        chk("rstw_addr_out", addr_out, 32'd0);
        chk("rstw_ctrl_out", ctrl_out, 3'd0);
        chk("rstw_regdst_out", regdst_out, 5'd0);
        chk("rstw_exc", {30'd0, exc_misalign, exc_bus}, 32'd0);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_wb", wb_valid, 1'b0);
        chk("late_ack_req", mem_req, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rop = $urandom_range(0, 2);
            rsz = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & ~(32'(nbytes(rsz)) - 32'd1);
            rk  = $urandom_range(1, TO + 2);
            run_txn(rop, rsz, 1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)),
                    $urandom, $urandom, rk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
